// File: rtl/pll_rstseq_pkg.sv
// rtl/pll_rstseq_pkg.sv - state encoding and default timing for the PLL reset sequencer
package pll_rstseq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SYS   = 3'd3,
        RUN       = 3'd4
    } seq_state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 100000;
    localparam int unsigned DEF_STABLE_CYCLES  = 5000;
    localparam int unsigned DEF_STAGE_GAP      = 16;

    // Zero-length phases would never let the counter reach a load value; clamp to one cycle.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with asynchronous active-low clear
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset, lock qualification and staged sys/cpu reset release
// Optional lock-loss counter output enabled by RSTSEQ_LOSS_CNT_EN.
module pll_reset_sequencer
    import pll_rstseq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               cpu_rst_n,
    output logic               clk_ready,
    output logic [STATE_W-1:0] seq_state
`ifdef RSTSEQ_LOSS_CNT_EN
    ,
    output logic [7:0]         loss_cnt
`endif
);

    localparam int unsigned RST_C = at_least_one(PLL_RST_CYCLES);
    localparam int unsigned TO_C  = at_least_one(LOCK_TIMEOUT);
    localparam int unsigned ST_C  = at_least_one(STABLE_CYCLES);
    localparam int unsigned GAP_C = at_least_one(STAGE_GAP);
    localparam int          CNT_W = $clog2(max4(RST_C, TO_C, ST_C, GAP_C)) + 1;

    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_C - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TO_C - 1);
    localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(ST_C - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_C - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lk;
    logic             pll_rst_q, sys_rst_n_q, cpu_rst_n_q, clk_ready_q;
    logic             cnt_zero;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    assign cnt_zero = (cnt_q == '0);

    // Lock loss is checked before soft reset so it always takes priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            PLL_RST: begin
                if (cnt_zero) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LD;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = ST_LD;
                end else if (cnt_zero) begin
                    state_d = PLL_RST;
                    cnt_d   = RST_LD;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LD;
                end else if (cnt_zero) begin
                    state_d = REL_SYS;
                    cnt_d   = GAP_LD;
                end
            end
            REL_SYS, RUN: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TO_LD;
                end else if (soft_rst_req) begin
                    state_d = STABLE;
                    cnt_d   = ST_LD;
                end else if (state_q == REL_SYS && cnt_zero) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = RST_LD;
            end
        endcase
    end

    // Outputs decode state_d so the first cycle in a state already shows its outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= RST_LD;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            clk_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == PLL_RST);
            sys_rst_n_q <= (state_d == REL_SYS) || (state_d == RUN);
            cpu_rst_n_q <= (state_d == RUN);
            clk_ready_q <= (state_d == RUN);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign clk_ready = clk_ready_q;
    assign seq_state = state_q;

`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;
    logic       loss_inc;

    assign loss_inc = ((state_q == REL_SYS) || (state_q == RUN)) && !lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= 8'h00;
        end else if (loss_inc && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'h01;
        end
    end

    assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed checks of the PLL reset sequencer
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       cpu_rst_n;
    logic       clk_ready;
    logic [2:0] seq_state;
`ifdef RSTSEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_total;
    int n_pass;
    int order_err;
    logic seen_rel;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .STAGE_GAP      (3)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .cpu_rst_n    (cpu_rst_n),
        .clk_ready    (clk_ready),
        .seq_state    (seq_state)
`ifdef RSTSEQ_LOSS_CNT_EN
        ,
        .loss_cnt     (loss_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    always @(negedge refclk) begin
        if (rst_n && cpu_rst_n && !sys_rst_n) order_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Lock rises now; lk follows two edges later, then 8 STABLE and 3 REL_SYS cycles.
    task automatic relock(input string tag);
        pll_locked = 1'b1;
        tick(10);
        check({tag, "_sys_hold"}, {31'd0, sys_rst_n}, 32'd0);
        check({tag, "_st_stable"}, {29'd0, seq_state}, 32'd2);
        tick(1);
        check({tag, "_sys_rel"}, {31'd0, sys_rst_n}, 32'd1);
        check({tag, "_st_relsys"}, {29'd0, seq_state}, 32'd3);
        check({tag, "_cpu_hold0"}, {31'd0, cpu_rst_n}, 32'd0);
        tick(2);
        check({tag, "_cpu_hold1"}, {31'd0, cpu_rst_n}, 32'd0);
        tick(1);
        check({tag, "_cpu_rel"}, {31'd0, cpu_rst_n}, 32'd1);
        check({tag, "_ready"}, {31'd0, clk_ready}, 32'd1);
        check({tag, "_st_run"}, {29'd0, seq_state}, 32'd4);
    endtask

    initial begin
        n_total = 0; n_pass = 0; order_err = 0; seen_rel = 1'b0;
        rst_n = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
        tick(3);
        check("rst_pll", {31'd0, pll_rst}, 32'd1);
        check("rst_sys", {31'd0, sys_rst_n}, 32'd0);
        check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_ready", {31'd0, clk_ready}, 32'd0);
        check("rst_state", {29'd0, seq_state}, 32'd0);
        rst_n = 1'b1;

        // 1: power-up, lock at cycle 10
        tick(3);
        check("t1_pll_c3", {31'd0, pll_rst}, 32'd1);
        tick(1);
        check("t1_pll_c4", {31'd0, pll_rst}, 32'd0);
        check("t1_st_wait", {29'd0, seq_state}, 32'd1);
        tick(6);
        relock("t1");

        // 4: lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        check("t4_sys_still", {31'd0, sys_rst_n}, 32'd1);
        tick(1);
        check("t4_sys_drop", {31'd0, sys_rst_n}, 32'd0);
        check("t4_cpu_drop", {31'd0, cpu_rst_n}, 32'd0);
        check("t4_ready_drop", {31'd0, clk_ready}, 32'd0);
        check("t4_st_wait", {29'd0, seq_state}, 32'd1);
`ifdef RSTSEQ_LOSS_CNT_EN
        check("t4_loss1", {24'd0, loss_cnt}, 32'd1);
`endif
        relock("t4");

        // 5: soft reset in RUN
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("t5_sys_asrt", {31'd0, sys_rst_n}, 32'd0);
        check("t5_cpu_asrt", {31'd0, cpu_rst_n}, 32'd0);
        check("t5_pll_low", {31'd0, pll_rst}, 32'd0);
        check("t5_st_stable", {29'd0, seq_state}, 32'd2);
        tick(7);
        check("t5_sys_hold", {31'd0, sys_rst_n}, 32'd0);
        tick(1);
        check("t5_sys_rel", {31'd0, sys_rst_n}, 32'd1);
        tick(2);
        check("t5_cpu_hold", {31'd0, cpu_rst_n}, 32'd0);
        tick(1);
        check("t5_cpu_rel", {31'd0, cpu_rst_n}, 32'd1);

        // soft reset ignored in WAIT_LOCK
        pll_locked = 1'b0;
        tick(3);
        check("t5_st_wait", {29'd0, seq_state}, 32'd1);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("t5_ign0", {29'd0, seq_state}, 32'd1);
        tick(1);
        check("t5_ign1", {29'd0, seq_state}, 32'd1);
`ifdef RSTSEQ_LOSS_CNT_EN
        check("t5_loss2", {24'd0, loss_cnt}, 32'd2);
`endif

        // 3: two-cycle glitch mid-STABLE
        pll_locked = 1'b1;
        tick(3);
        check("t3_st_stable", {29'd0, seq_state}, 32'd2);
        tick(3);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(1);
        check("t3_requal", {29'd0, seq_state}, 32'd1);
        tick(9);
        check("t3_sys_hold", {31'd0, sys_rst_n}, 32'd0);
        check("t3_st_stable2", {29'd0, seq_state}, 32'd2);
        tick(1);
        check("t3_sys_rel", {31'd0, sys_rst_n}, 32'd1);
        check("t3_st_relsys", {29'd0, seq_state}, 32'd3);

        // 6: async reset mid-REL_SYS
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_pll", {31'd0, pll_rst}, 32'd1);
        check("t6_sys", {31'd0, sys_rst_n}, 32'd0);
        check("t6_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("t6_state", {29'd0, seq_state}, 32'd0);
`ifdef RSTSEQ_LOSS_CNT_EN
        check("t6_loss0", {24'd0, loss_cnt}, 32'd0);
`endif
        pll_locked = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("t6_pll_c3", {31'd0, pll_rst}, 32'd1);
        tick(1);
        check("t6_pll_c4", {31'd0, pll_rst}, 32'd0);
        check("t6_st_wait", {29'd0, seq_state}, 32'd1);

        // 2: no lock, PLL reset re-pulses every 24 cycles
        for (int i = 0; i < 19; i++) begin
            tick(1);
            seen_rel = seen_rel | sys_rst_n | cpu_rst_n;
        end
        check("t2_pll_c23", {31'd0, pll_rst}, 32'd0);
        tick(1);
        check("t2_pll_c24", {31'd0, pll_rst}, 32'd1);
        check("t2_st_pllrst", {29'd0, seq_state}, 32'd0);
        tick(3);
        check("t2_pll_c27", {31'd0, pll_rst}, 32'd1);
        tick(1);
        check("t2_pll_c28", {31'd0, pll_rst}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen_rel = seen_rel | sys_rst_n | cpu_rst_n;
        end
        check("t2_pll_c48", {31'd0, pll_rst}, 32'd1);
        check("t2_no_release", {31'd0, seen_rel}, 32'd0);

        check("order", order_err, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
